// File: rtl/derandomizer.sv
// Receive-side CCSDS complex-symbol derandomizer: regenerates the Gold-sequence
// rotation index locked to sof and multiplies each symbol by j^(-R).
module derandomizer #(
  parameter int W         = 8,
  parameter int FRAME_LEN = 1024
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sof,
  input  logic signed [W-1:0] i_i,
  input  logic signed [W-1:0] i_q,
  output logic                o_valid,
  input  logic                i_ready,
  output logic signed [W-1:0] o_i,
  output logic signed [W-1:0] o_q,
  output logic                o_sof,
  output logic                o_eof,
  output logic                o_locked,
  output logic                o_err
);

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [17:0]         X_SEED = 18'h00001;
  localparam logic [17:0]         Y_SEED = 18'h3FFFF;
  localparam logic [15:0]         FLEN   = 16'(FRAME_LEN);
  localparam logic signed [W-1:0] S_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] S_MAX  = {1'b0, {(W-1){1'b1}}};

  function automatic logic [17:0] x_next(input logic [17:0] x);
    return {x[7] ^ x[0], x[17:1]};
  endfunction

  function automatic logic [17:0] y_next(input logic [17:0] y);
    return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
  endfunction

  function automatic logic [1:0] rot_idx(input logic [17:0] x, input logic [17:0] y);
    logic z1;
    logic z2;
    z1 = x[4] ^ x[6] ^ x[15];
    z2 = y[5] ^ y[6] ^ (^y[15:8]);
    return {z1 ^ z2, x[0] ^ y[0]};
  endfunction

  // The most negative sample has no positive twin, so it clamps to the maximum.
  function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] a);
    return (a == S_MIN) ? S_MAX : -a;
  endfunction

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [17:0]           x_q, x_d, y_q, y_d;
  logic                  valid_q, valid_d;
  logic signed [W-1:0]   out_i_q, out_i_d, out_q_q, out_q_d;
  logic                  sof_q, sof_d, eof_q, eof_d, err_q, err_d;
  logic                  accept_s, emit_s;
  logic [17:0]           gx_s, gy_s;
  logic [1:0]            r_s;

  assign o_ready  = !valid_q || i_ready;
  assign accept_s = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q && !i_ready;
    out_i_d = out_i_q;
    out_q_d = out_q_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    err_d   = 1'b0;
    emit_s  = 1'b0;
    gx_s    = x_q;
    gy_s    = y_q;
    r_s     = 2'd0;

    if (accept_s) begin
      if (i_sof) begin
        // Mid-frame sof is an error but still restarts the frame from the seed.
        emit_s  = 1'b1;
        gx_s    = X_SEED;
        gy_s    = Y_SEED;
        state_d = TRACK;
        cnt_d   = 16'd1;
        err_d   = (state_q == TRACK) && (cnt_q != FLEN);
        sof_d   = 1'b1;
        eof_d   = 1'b0;
      end else if ((state_q == TRACK) && (cnt_q != FLEN)) begin
        emit_s  = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        sof_d   = 1'b0;
        eof_d   = ((cnt_q + 16'd1) == FLEN);
      end else if (state_q == TRACK) begin
        err_d   = 1'b1;
        state_d = HUNT;
      end else begin
        state_d = HUNT;
      end
    end else begin
      state_d = state_q;
    end

    if (emit_s) begin
      r_s     = rot_idx(gx_s, gy_s);
      x_d     = x_next(gx_s);
      y_d     = y_next(gy_s);
      valid_d = 1'b1;
      case (r_s)
        2'd0: begin out_i_d = i_i;          out_q_d = i_q;          end
        2'd1: begin out_i_d = i_q;          out_q_d = sat_neg(i_i); end
        2'd2: begin out_i_d = sat_neg(i_i); out_q_d = sat_neg(i_q); end
        2'd3: begin out_i_d = sat_neg(i_q); out_q_d = i_i;          end
        default: begin out_i_d = i_i;       out_q_d = i_q;          end
      endcase
    end else begin
      r_s = 2'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= HUNT;
      cnt_q   <= 16'd0;
      x_q     <= X_SEED;
      y_q     <= Y_SEED;
      valid_q <= 1'b0;
      out_i_q <= '0;
      out_q_q <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      out_i_q <= out_i_d;
      out_q_q <= out_q_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_i      = out_i_q;
  assign o_q      = out_q_q;
  assign o_sof    = sof_q;
  assign o_eof    = eof_q;
  assign o_err    = err_q;
  assign o_locked = (state_q == TRACK);

endmodule

// File: tb/tb_derandomizer.sv
// Directed-plus-random bench for derandomizer, checked against a frame-level
// scoreboard built from the Gold-sequence rules and symbol rotation arithmetic.
module tb_derandomizer;
  localparam int W    = 8;
  localparam int FLEN = 1024;
  localparam int SMAX = 2**(W-1) - 1;

  logic                i_clk = 1'b0;
  logic                i_reset, i_valid, i_sof, i_ready;
  logic signed [W-1:0] i_i, i_q, o_i, o_q;
  logic                o_ready, o_valid, o_sof, o_eof, o_locked, o_err;

  derandomizer #(.W(W), .FRAME_LEN(FLEN)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_sof(i_sof), .i_i(i_i), .i_q(i_q), .o_valid(o_valid), .i_ready(i_ready),
    .o_i(o_i), .o_q(o_q), .o_sof(o_sof), .o_eof(o_eof), .o_locked(o_locked),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int i; int q; bit sof; bit eof; } item_t;

  int    vec_cnt = 0;
  int    mis_cnt = 0;
  int    gold [FLEN];
  item_t exp_q [$];
  int    log_i [$];
  int    log_q [$];
  bit    m_track = 0;
  int    m_n = 0;
  bit    exp_err = 0;
  logic  dummy;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    vec_cnt++;
    assert (got === exp) else begin
      mis_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  // Multiply (i + jq) by j^(-r): each quarter turn back maps (a,b) to (b,-a).
  function automatic void rot(input int i, input int q, input int r, output int oi, output int oq);
    case (r)
      0: begin oi = i;       oq = q;       end
      1: begin oi = q;       oq = sat(-i); end
      2: begin oi = sat(-i); oq = sat(-q); end
      default: begin oi = sat(-q); oq = i; end
    endcase
  endfunction

  function automatic void build_gold();
    int x, y, z1, z2;
    x = 1;
    y = 262143;
    for (int n = 0; n < FLEN; n++) begin
      z1 = ((x >> 4) ^ (x >> 6) ^ (x >> 15)) & 1;
      z2 = ((y >> 5) ^ (y >> 6)) & 1;
      for (int b = 8; b <= 15; b++) z2 ^= (y >> b) & 1;
      gold[n] = ((z1 ^ z2) << 1) | ((x ^ y) & 1);
      x = ((((x >> 7) ^ x) & 1) << 17) | (x >> 1);
      y = ((((y >> 10) ^ (y >> 7) ^ (y >> 5) ^ y) & 1) << 17) | (y >> 1);
    end
  endfunction

  function automatic void model_accept(input bit s, input int ii, input int qq);
    item_t it;
    if (s) begin
      exp_err = m_track && (m_n < FLEN);
      m_track = 1;
      rot(ii, qq, gold[0], it.i, it.q);
      it.sof = 1; it.eof = 0;
      exp_q.push_back(it);
      m_n = 1;
    end else if (!m_track) begin
      exp_err = 0;
    end else if (m_n == FLEN) begin
      exp_err = 1;
      m_track = 0;
    end else begin
      rot(ii, qq, gold[m_n], it.i, it.q);
      it.sof = 0; it.eof = (m_n + 1 == FLEN);
      exp_q.push_back(it);
      m_n++;
    end
  endfunction

  // One clock cycle: drive at negedge, check the held output, update the model at posedge.
  task automatic step(input logic v, input logic s, input int ii, input int qq, input logic rdy, output logic acc);
    bit mready;
    i_valid = v; i_sof = s; i_i = ii[W-1:0]; i_q = qq[W-1:0]; i_ready = rdy;
    #1;
    mready = (exp_q.size() == 0) || rdy;
    chk("o_valid", o_valid, exp_q.size() > 0);
    chk("o_ready", o_ready, mready);
    if (exp_q.size() > 0) begin
      chk("o_i", o_i, exp_q[0].i);
      chk("o_q", o_q, exp_q[0].q);
      chk("o_sof", o_sof, exp_q[0].sof);
      chk("o_eof", o_eof, exp_q[0].eof);
      if (rdy) begin
        log_i.push_back(exp_q[0].i == int'(o_i) ? int'(o_i) : exp_q[0].i);
        log_q.push_back(int'(o_q));
        log_i[log_i.size()-1] = int'(o_i);
        void'(exp_q.pop_front());
      end
    end
    acc = v && mready;
    @(posedge i_clk);
    exp_err = 0;
    if (acc) model_accept(s, ii, qq);
    @(negedge i_clk);
    chk("o_err", o_err, exp_err);
    chk("o_locked", o_locked, m_track);
  endtask

  task automatic send(input logic s, input int ii, input int qq, input bit bp, input bit gaps);
    logic acc;
    logic rdy;
    int   tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 100) begin
      rdy = bp ? logic'($urandom_range(0, 1)) : 1'b1;
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 0, 0, rdy, dummy);
      rdy = bp ? logic'($urandom_range(0, 1)) : 1'b1;
      step(1'b1, s, ii, qq, rdy, acc);
      tries++;
    end
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_locked", o_locked, 1'b0);
    chk("rst_o_err", o_err, 1'b0);
    m_track = 0; m_n = 0; exp_q.delete();
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic check_anchor(input string tag);
    chk({tag, "_i0"}, log_i[0], 10);  chk({tag, "_q0"}, log_q[0], 3);
    chk({tag, "_i1"}, log_i[1], 3);   chk({tag, "_q1"}, log_q[1], -10);
    chk({tag, "_i2"}, log_i[2], 3);   chk({tag, "_q2"}, log_q[2], -10);
  endtask

  initial begin
    build_gold();
    i_reset = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_ready = 1'b0; i_i = '0; i_q = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_o_valid", o_valid, 1'b0);
    chk("reset_o_ready", o_ready, 1'b1);
    chk("reset_o_locked", o_locked, 1'b0);
    chk("reset_o_err", o_err, 1'b0);
    chk("reset_o_sof", o_sof, 1'b0);
    chk("reset_o_eof", o_eof, 1'b0);
    chk("reset_o_i", o_i, 0);
    chk("reset_o_q", o_q, 0);
    i_reset = 1'b0;

    // HUNT drops non-sof symbols; then the saturating negation of -128.
    for (int k = 0; k < 5; k++) send(1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0);
    log_i.delete(); log_q.delete();
    send(1'b1, -128, 5, 1'b0, 1'b0);
    for (int k = 1; k < 60; k++) send(1'b0, -128, rnd_s(), 1'b0, 1'b0);
    chk("hunt_first_i", log_i[0], -128);
    chk("hunt_first_q", log_q[0], 5);
    for (int k = 1; k < log_i.size(); k++) begin
      if (gold[k] == 2) begin
        chk("sat_neg_i", log_i[k], SMAX);
        break;
      end
    end
    do_reset();

    // Constant-symbol frame, then a back-to-back frame under random backpressure.
    log_i.delete(); log_q.delete();
    send(1'b1, 10, 3, 1'b0, 1'b0);
    for (int k = 1; k < FLEN; k++) send(1'b0, 10, 3, 1'b0, 1'b0);
    check_anchor("seq");
    send(1'b1, rnd_s(), rnd_s(), 1'b1, 1'b1);
    for (int k = 1; k < FLEN; k++) send(1'b0, rnd_s(), rnd_s(), 1'b1, 1'b1);

    // Back-to-back frame aborted by sof at symbol 500.
    send(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
    for (int k = 1; k < 500; k++) send(1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0);
    send(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
    for (int k = 1; k < FLEN; k++) send(1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0);

    // Non-sof after a complete frame: error, drop, lock lost.
    send(1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0);
    send(1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0);

    // Reset mid-frame at symbol 300, then the sequence restarts from R=0.
    send(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
    for (int k = 1; k < 300; k++) send(1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0);
    do_reset();
    log_i.delete(); log_q.delete();
    send(1'b1, 10, 3, 1'b0, 1'b0);
    for (int k = 1; k < 6; k++) send(1'b0, 10, 3, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 0, 1'b1, dummy);
    check_anchor("post_reset");
    chk("drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end
endmodule
